// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the execute/writeback datapath.
//   - ALU opcode constants as produced by execute
//   - REG_AW: register-number width
//   - wb_state_e: writeback FSM state encoding
package rv_pkg;

  localparam int REG_AW = 5;

  localparam logic [4:0] ALU_JAL  = 5'b10000;
  localparam logic [4:0] ALU_BEQ  = 5'b10001;
  localparam logic [4:0] ALU_BLT  = 5'b10010;
  localparam logic [4:0] ALU_LW   = 5'b10100;
  localparam logic [4:0] ALU_SW   = 5'b10101;
  localparam logic [4:0] ALU_ADDI = 5'b01100;
  localparam logic [4:0] ALU_ADD  = 5'b01101;
  localparam logic [4:0] ALU_SUB  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_AND  = 5'b00100;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry integer register array, two combinational read
// ports and one synchronous write port. x0 always reads as zero and is
// never written.
//
// Build option: WB_BYPASS_EN -- when defined, a read port addressing the
// register being written this cycle returns the incoming write data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears array)
//   we_i, waddr_i, wdata_i   write port (write is committed at the posedge)
//   rs1_addr_i, rs1_data_o   read port 1
//   rs2_addr_i, rs2_data_o   read port 2
module regfile_2r1w
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o
);

  logic [XLEN-1:0] r_mem [32];
  logic            w_we_nz;

  assign w_we_nz = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_we_nz) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_data_o = (rs1_addr_i == '0) ? '0 :
                      (w_we_nz && rs1_addr_i == waddr_i) ? wdata_i : r_mem[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 :
                      (w_we_nz && rs2_addr_i == waddr_i) ? wdata_i : r_mem[rs2_addr_i];
`else
  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : r_mem[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : r_mem[rs2_addr_i];
`endif

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Commits execute results into the register
// file, completes loads by waiting for the memory read response (stalling
// upstream meanwhile), and exposes the two decode read ports.
//
// Build option: WB_BYPASS_EN (passed through to regfile_2r1w) enables
// same-cycle write-to-read bypass on the read ports.
//
// State table:
//   IDLE      | accepting execute results; non-load writes commit at once
//   WAIT_LOAD | load issued, waiting for mem_rvalid_i or timeout
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wb_we_i/waddr_i/wdata_i/aluop_i  execute result interface
//   mem_rvalid_i, mem_rdata_i        load response (single-cycle pulse)
//   rs1/rs2_addr_i, rs1/rs2_data_o   decode read ports
//   stall_o                          upstream must hold its inputs
//   load_err_o                       sticky: a load timed out
//   retire_cnt_o                     number of committed register writes
module wb_regfile
  import rv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int XLEN         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_waddr_i,
  input  logic [XLEN-1:0]   wb_wdata_i,
  input  logic [4:0]        wb_aluop_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              stall_o,
  output logic              load_err_o,
  output logic [31:0]       retire_cnt_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_e         r_state;
  logic [7:0]        r_cnt;
  logic [REG_AW-1:0] r_ld_addr;
  logic              r_ld_en;
  logic              r_err;
  logic [31:0]       r_retire;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_wr_en;
  logic [REG_AW-1:0] w_wr_addr;
  logic [XLEN-1:0]   w_wr_data;
  logic              w_commit;
  logic              w_stall;

  assign w_is_load  = (wb_aluop_i == ALU_LW);
  assign w_is_store = (wb_aluop_i == ALU_SW);

  // Write-port selection. Everything is forced quiet while rst is high so
  // that neither a write nor a stall can leak out of a reset cycle.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = wb_waddr_i;
    w_wr_data = wb_wdata_i;
    w_stall   = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_is_load) begin
            w_wr_data = mem_rdata_i;
            if (mem_rvalid_i) w_wr_en = wb_we_i;
            else              w_stall = 1'b1;
          end else if (!w_is_store) begin
            w_wr_en = wb_we_i;
          end
        end
        WAIT_LOAD: begin
          w_wr_addr = r_ld_addr;
          w_wr_data = mem_rdata_i;
          if (mem_rvalid_i) w_wr_en = r_ld_en;
          else              w_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // x0 writes are dropped here so they also never count as retired.
  assign w_commit = w_wr_en && (w_wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ld_addr <= '0;
      r_ld_en   <= 1'b0;
      r_err     <= 1'b0;
      r_retire  <= '0;
    end else begin
      if (w_commit) r_retire <= r_retire + 32'd1;
      case (r_state)
        IDLE: begin
          if (w_is_load && !mem_rvalid_i) begin
            r_state   <= WAIT_LOAD;
            r_ld_addr <= wb_waddr_i;
            r_ld_en   <= wb_we_i && (wb_waddr_i != '0);
            r_cnt     <= '0;
          end
        end
        WAIT_LOAD: begin
          // A response arriving in the last allowed cycle still completes.
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o      = w_stall;
  assign load_err_o   = r_err;
  assign retire_cnt_o = r_retire;

  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (w_commit),
    .waddr_i    (w_wr_addr),
    .wdata_i    (w_wr_data),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile. A driver issues one
// input vector per cycle and pushes the expected outputs, computed from a
// behavioural model, into a queue; a monitor pops and compares on the
// falling edge.
module tb_wb_regfile;

  localparam int TO = 16;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_SW  = 5'b10101;
  localparam logic [4:0] OP_ADD = 5'b01101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_waddr_i = '0;
  logic [31:0] wb_wdata_i = '0;
  logic [4:0]  wb_aluop_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic [31:0] rs1_data_o, rs2_data_o, retire_cnt_o;
  logic        stall_o, load_err_o;

  wb_regfile #(.LOAD_TIMEOUT(TO), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .wb_aluop_i(wb_aluop_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .stall_o(stall_o), .load_err_o(load_err_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        err;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   drv_done = 1'b0;

  // Reference model: architectural register contents plus an outstanding
  // load descriptor (destination, whether it will write, cycles waited).
  logic [31:0] m_regs [32];
  bit          m_pending;
  logic [4:0]  m_ld_dst;
  bit          m_ld_wr;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_ret;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pending = 0; m_ld_dst = '0; m_ld_wr = 0; m_waited = 0;
    m_err = 0; m_ret = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit wr,
                                             input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = m_regs[a];
`ifdef WB_BYPASS_EN
    if (wr && wa == a) v = wd;
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, predict, push, then advance the model.
  task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] op, input bit rv, input logic [31:0] rd,
                     input logic [4:0] a1, input logic [4:0] a2);
    exp_t        e;
    bit          wr;
    logic [4:0]  wr_a;
    logic [31:0] wr_d;
    @(posedge clk); #1;
    rst = r; wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd; wb_aluop_i = op;
    mem_rvalid_i = rv; mem_rdata_i = rd; rs1_addr_i = a1; rs2_addr_i = a2;

    wr = 0; wr_a = wa; wr_d = wd; e.stall = 0;
    if (!r) begin
      if (m_pending) begin
        if (rv) begin wr = m_ld_wr; wr_a = m_ld_dst; wr_d = rd; end
        else e.stall = 1;
      end else if (op == OP_LW) begin
        if (rv) begin wr = we && wa != 0; wr_d = rd; end
        else e.stall = 1;
      end else if (op != OP_SW) begin
        wr = we && wa != 0;
      end
    end
    e.r1  = model_read(a1, wr, wr_a, wr_d);
    e.r2  = model_read(a2, wr, wr_a, wr_d);
    e.err = m_err;
    e.ret = m_ret;
    q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (wr) begin m_regs[wr_a] = wr_d; m_ret = m_ret + 1; end
      if (m_pending) begin
        m_waited++;
        if (rv) m_pending = 0;
        else if (m_waited == TO) begin m_pending = 0; m_err = 1; end
      end else if (op == OP_LW && !rv) begin
        m_pending = 1; m_ld_dst = wa; m_ld_wr = we && wa != 0; m_waited = 0;
      end
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_o",      {31'd0, stall_o},    {31'd0, e.stall});
        chk("rs1_data_o",   rs1_data_o,          e.r1);
        chk("rs2_data_o",   rs2_data_o,          e.r2);
        chk("load_err_o",   {31'd0, load_err_o}, {31'd0, e.err});
        chk("retire_cnt_o", retire_cnt_o,        e.ret);
      end
    end
  end

  // Driver
  initial begin
    logic [4:0]  op, wa;
    logic [31:0] wd;
    int          rv_pct;
    model_reset();
    @(posedge clk);

    // Reset then add; read back next cycle.
    cyc(1, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    cyc(0, 1, 5, 32'h1234, OP_ADD, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 5, 5);
    // x0 write discarded.
    cyc(0, 1, 0, 32'hFFFF_FFFF, OP_ADD, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 0, 5);
    // Store ignored.
    cyc(0, 1, 7, 32'hAA, OP_SW, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 7, 7);
    // Delayed load: entry + 4 stall cycles, response on the 5th wait cycle;
    // wb inputs during the stall must not be written.
    cyc(0, 1, 3, 0, OP_LW, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 6, 32'h1111_0000 + i, OP_ADD, 0, 0, 3, 6);
    cyc(0, 1, 6, 32'h2222, OP_ADD, 1, 32'hDEAD_BEEF, 3, 6);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 3, 6);
    // Timeout.
    cyc(0, 1, 9, 0, OP_LW, 0, 0, 9, 0);
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, OP_ADD, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 9, 0);
    // Response in the final timeout cycle still completes.
    cyc(0, 1, 10, 0, OP_LW, 0, 0, 10, 0);
    for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, OP_ADD, 0, 0, 10, 0);
    cyc(0, 0, 0, 0, OP_ADD, 1, 32'hCAFE_0010, 10, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 10, 0);
    // Reset in the 2nd wait cycle; a later rvalid writes nothing.
    cyc(0, 1, 9, 0, OP_LW, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 9, 0);
    cyc(1, 0, 0, 0, OP_ADD, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, OP_ADD, 1, 32'h5A5A_5A5A, 9, 0);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 9, 0);
    // Same-cycle write/read of x4.
    cyc(0, 1, 4, 32'h55, OP_ADD, 0, 0, 0, 4);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 4, 4);
    // Load completing in the same cycle, with bypass visibility.
    cyc(0, 1, 12, 0, OP_LW, 1, 32'h0BAD_F00D, 12, 12);
    cyc(0, 0, 0, 0, OP_ADD, 0, 0, 12, 0);

    // Randomised traffic: first half frequent responses, second half rare
    // ones so that timeouts occur.
    for (int n = 0; n < 3000; n++) begin
      rv_pct = (n < 1500) ? 30 : 4;
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_LW;
        3:       op = OP_SW;
        default: begin
          op = 5'($urandom);
          while (op == OP_LW || op == OP_SW) op = 5'($urandom);
        end
      endcase
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd = $urandom;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, wa, wd, op,
          $urandom_range(0, 99) < rv_pct, $urandom,
          ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7)),
          5'($urandom));
    end

    @(posedge clk); #1;
    wb_we_i = 0; mem_rvalid_i = 0; wb_aluop_i = OP_ADD;
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    if (!drv_done) chk("driver_done", 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
